imem_loader: RTL and testbench

Writer side of the instruction memory: accepts a stream of 16-bit halfwords over a valid/ready handshake, assembles pairs into 32-bit instructions, and writes them into consecutive instruction-memory slots. The fetch path consumes these slots at `pc`, stepping by 2. The loader sits between the external program source and the instruction-memory write port. It is active only while the CPU is held off fetch.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 21 ++
 rtl/loader_cksum.sv | 24 ++
 rtl/imem_loader.sv | 98 +++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-memory loader state type.
package cpu_pkg;

    localparam int ADDR_W  = 7;
    localparam int HALF_W  = 16;
    localparam int INSTR_W = 2 * HALF_W;

    localparam logic [ADDR_W-1:0] PC_STEP   = 7'd2;
    localparam logic [ADDR_W-1:0] MAX_INSTR = 7'd64;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~7'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } loader_state_t;

    function automatic logic [ADDR_W-1:0] sat_count(input logic [ADDR_W-1:0] c);
        return (c > MAX_INSTR) ? MAX_INSTR : c;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Halfword input stream plus instruction-memory write port of the loader.
interface imem_loader_if;
    import cpu_pkg::*;

    logic               in_valid;
    logic [HALF_W-1:0]  in_data;
    logic               in_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/loader_cksum.sv
// Halfword accumulator (sum modulo 2^16) with clear and enable.
// Only built when IMEM_LOADER_CHECKSUM_EN is defined.
`ifdef IMEM_LOADER_CHECKSUM_EN
module loader_cksum
    import cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [HALF_W-1:0] i_data,
    output logic [HALF_W-1:0] o_sum
);
    logic [HALF_W-1:0] r_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_sum <= '0;
        else if (i_clr) r_sum <= '0;
        else if (i_en)  r_sum <= r_sum + i_data;
    end

    assign o_sum = r_sum;
endmodule
`endif

// File: rtl/imem_loader.sv
// Assembles halfword pairs into 32-bit instructions and writes consecutive imem slots.
// Define IMEM_LOADER_CHECKSUM_EN to build the running halfword checksum.
module imem_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    imem_loader_if.slave      bus,
    output logic              busy,
    output logic              done,
    output logic [HALF_W-1:0] checksum
);
    loader_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_remain;
    logic [HALF_W-1:0]  r_lo;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [INSTR_W-1:0] r_wr_data;
    logic               r_done;

    logic               w_ready;
    logic               w_hs;
    logic               w_start_acc;
    logic [ADDR_W-1:0]  w_cnt_sat;

    assign w_ready     = (r_state == LO) || (r_state == HI);
    assign w_hs        = bus.in_valid && w_ready;
    assign w_start_acc = start && (r_state == IDLE);
    assign w_cnt_sat   = sat_count(count);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = (w_cnt_sat == '0) ? FIN : LO;
            LO:      if (w_hs) w_state_nxt = HI;
            HI:      if (w_hs) w_state_nxt = (r_remain == 7'd1) ? FIN : LO;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_remain  <= '0;
            r_lo      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= 1'b0;
            // done is a registered copy of FIN, so it lands the cycle after the last write
            r_done  <= (r_state == FIN);
            if (w_start_acc) begin
                r_addr   <= base_addr & ADDR_MASK;
                r_remain <= w_cnt_sat;
            end
            if (w_hs && (r_state == LO)) begin
                r_lo <= bus.in_data;
            end
            if (w_hs && (r_state == HI)) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= {bus.in_data, r_lo};
                r_addr    <= r_addr + PC_STEP;
                r_remain  <= r_remain - 7'd1;
            end
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign busy         = (r_state != IDLE);
    assign done         = r_done;

`ifdef IMEM_LOADER_CHECKSUM_EN
    loader_cksum u_cksum (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_start_acc),
        .i_en    (w_hs),
        .i_data  (bus.in_data),
        .o_sum   (checksum)
    );
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed scoreboard bench for imem_loader.
module tb_imem_loader;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  base_addr;
    logic [6:0]  count;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    imem_loader_if bus ();

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    int  n_cmp  = 0;
    int  n_fail = 0;
    int  done_cnt = 0;
    logic prev_wr = 1'b0;
    logic prev_done = 1'b0;
    wr_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_ck(input logic [15:0] sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
        return sum;
`else
        return (sum & 16'h0000);
`endif
    endfunction

    // Write-port monitor: pops the scoreboard on each write strobe
    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            if (bus.wr_en) begin
                check("wr_en_1cyc", 32'(prev_wr), 32'd0);
                check("wr_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                    check("wr_data", bus.wr_data, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_1cyc", 32'(prev_done), 32'd0);
            end
            prev_wr   <= bus.wr_en;
            prev_done <= done;
        end else begin
            prev_wr   <= 1'b0;
            prev_done <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] b, input logic [6:0] c);
        start = 1'b1; base_addr = b; count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready_timeout", 32'(n < 50), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_check(input logic [15:0] sum);
        check("wr_en_last", 32'(bus.wr_en), 32'd1);
        check("done_early", 32'(done), 32'd0);
        tick();
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("ready_at_done", 32'(bus.in_ready), 32'd0);
        check("checksum", 32'(checksum), 32'(exp_ck(sum)));
        tick();
        check("done_drop", 32'(done), 32'd0);
    endtask

    task automatic run_load(input logic [6:0] b, input logic [6:0] c, input int n,
                            input logic [15:0] seed, input logic [15:0] step);
        logic [6:0]  a;
        logic [15:0] lo, hi, sum;
        a = b & 7'h7E;
        sum = 16'h0;
        do_start(b, c);
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            lo = seed + 16'(step * 16'(2 * i));
            hi = seed + 16'(step * 16'(2 * i + 1));
            sb.push_back('{a, {hi, lo}});
            a = a + 7'd2;
            sum = sum + lo + hi;
            send(lo);
            send(hi);
        end
        finish_check(sum);
    endtask

    initial begin
        int d0;
        reset = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Basic load: 0x22221111@0x10, 0x44443333@0x12
        run_load(7'h10, 7'd2, 2, 16'h1111, 16'h1111);
        check("basic_checksum", 32'(checksum), 32'(exp_ck(16'hAAAA)));

        // Wrap-around from 0x7E to 0x00
        run_load(7'h7E, 7'd2, 2, 16'hA5A5, 16'h1234);

        // Saturated count (100 -> 64) with odd base (bit 0 dropped)
        run_load(7'h21, 7'd100, 64, 16'h0101, 16'h0357);

        // Stall between the low and high halves
        do_start(7'h40, 7'd1);
        sb.push_back('{7'h40, 32'hBEEF_CAFE});
        send(16'hCAFE);
        for (int i = 0; i < 3; i++) begin
            check("stall_no_wr", 32'(bus.wr_en), 32'd0);
            check("stall_ready", 32'(bus.in_ready), 32'd1);
            bus.in_data = 16'h5555;
            tick();
        end
        send(16'hBEEF);
        finish_check(16'hCAFE + 16'hBEEF);

        // Zero count
        d0 = done_cnt;
        do_start(7'h08, 7'd0);
        check("zero_busy_t1", 32'(busy), 32'd1);
        check("zero_ready_t1", 32'(bus.in_ready), 32'd0);
        check("zero_done_t1", 32'(done), 32'd0);
        tick();
        check("zero_done_t2", 32'(done), 32'd1);
        check("zero_ready_t2", 32'(bus.in_ready), 32'd0);
        tick();
        check("zero_done_t3", 32'(done), 32'd0);
        check("zero_done_count", done_cnt - d0, 32'd1);

        // Start during HI must be ignored
        d0 = done_cnt;
        do_start(7'h30, 7'd2);
        sb.push_back('{7'h30, 32'h0002_0001});
        sb.push_back('{7'h32, 32'h0004_0003});
        send(16'h0001);
        start = 1'b1; base_addr = 7'h50; count = 7'd1;
        send(16'h0002);
        start = 1'b0;
        send(16'h0003);
        send(16'h0004);
        finish_check(16'h000A);
        tick(); tick();
        check("ign_done_count", done_cnt - d0, 32'd1);

        // Reset after only the low half
        do_start(7'h60, 7'd2);
        send(16'hDEAD);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("mid_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("mid_rst_wr_data", bus.wr_data, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_checksum", 32'(checksum), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        run_load(7'h02, 7'd1, 1, 16'h0F0F, 16'h0101);

        tick(); tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
